alu_seq: RTL and testbench
==========================

# alu_seq

Registered, handshaked successor to the combinational flag-producing ALU. It widens the operation set to eight ops: add, sub, and, or, xor, logical shift left, arithmetic shift right, and a multi-cycle unsigned multiply. All four status flags are defined for every op, and result plus flags are held in an output register under a valid/ready handshake. It sits between the decode/issue stage and writeback, and holds one operation in flight at a time.

## Interface
- WIDTH, 8, data width of operands and result; must be ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented on src_a/src_b/ALU_Control
- in_ready  output  1  block can accept an operation this cycle
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for shifts
- ALU_Control  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 sar, 111 mul
- out_valid  output  1  ALU_out and flags hold a result
- out_ready  input  1  consumer takes the result
- ALU_out  output  WIDTH  registered result
- zero_flag  output  1  ALU_out == 0
- carry_flag  output  1  per-op carry, see Operation
- sign_flag  output  1  ALU_out[WIDTH-1]
- overflow_flag  output  1  per-op overflow, see Operation

## Operation
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - ALU_out = 0
  - all four flags = 0
  - in_ready = 0 while reset is high
- Acceptance occurs on a rising edge where in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset.
- State machine:
  - IDLE → IDLE when a non-mul op is accepted; the result is registered at the accept edge.
  - IDLE → MUL when a mul op is accepted; operands are latched and the iteration counter is loaded with WIDTH.
  - MUL runs one shift-add step per cycle. The counter decrements. When the counter reaches 0, the low WIDTH bits go to ALU_out, out_valid is set, and state returns to IDLE.
- The output register is loaded only on completion. out_valid clears on out_valid && out_ready unless a new result loads on the same edge; a new load wins.
- Flags are registered together with ALU_out and stay stable while out_valid && !out_ready.
- add:
  - carry = bit WIDTH of {1'b0,a} + {1'b0,b}
  - overflow = operands have the same sign and the result sign differs
- sub:
  - carry = bit WIDTH of {1'b0,a} − {1'b0,b}, i.e. a borrow, which is 1 iff a < b unsigned
  - overflow = operands have different signs and the result sign differs from a
- and, or, xor: carry = 0, overflow = 0. Never X.
- shl, sar:
  - shift amount s = src_b[$clog2(WIDTH)-1:0]
  - carry = last bit shifted out, or 0 if s = 0
  - overflow = 0
  - sar replicates bit WIDTH-1
- mul:
  - unsigned 2·WIDTH-bit product; ALU_out = low half
  - carry = overflow = (high half != 0)
- zero_flag and sign_flag are always derived from the registered ALU_out.
- Reset mid-MUL aborts the operation. No result is produced, and the next accept is allowed on the first cycle after reset deasserts.
- in_valid while in_ready = 0 is ignored. The producer must hold its request until it is accepted.

## Timing
- Non-mul latency is 1: for an op accepted at edge k, out_valid is high after edge k.
- Throughput is 1 op/cycle when out_ready is held high, since a load and a consume can happen on the same edge.
- mul latency is WIDTH cycles: for an op accepted at edge k, out_valid rises after edge k+WIDTH.
- in_ready stays low from edge k until state returns to IDLE.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and ALU_out and flags are frozen.
- Inputs are sampled only at the accept edge. Later changes to src_a, src_b or ALU_Control do not affect an operation in flight.

## Test plan
- Signed-overflow add, WIDTH=8: add 0x7F + 0x01 → next cycle ALU_out=0x80, overflow=1, sign=1, carry=0, zero=0, out_valid=1.
- Borrow on sub: sub 0x00 − 0x01 → 0xFF, carry=1, sign=1, overflow=0. Then sub 0x80 − 0x01 → 0x7F, overflow=1.
- Multiply: mul 0x10 × 0x10 → out_valid exactly 8 cycles after accept, ALU_out=0x00, zero=1, carry=overflow=1. in_ready is low for all 8 cycles. Then mul 0x0F × 0x11 → 0xFF, carry=0.
- Shift and logic ops with back-to-back issue: with out_ready=1, issue sar 0x81 by 1, shl 0x81 by 1, and xor 0xAA^0xAA on consecutive cycles. Expect one result per cycle:
  - sar → 0xC0, carry=1
  - shl → 0x02, carry=1
  - xor → 0x00, zero=1, carry=overflow=0
- Backpressure: hold out_ready=0 for 5 cycles after an add result. ALU_out and flags must be unchanged and in_ready=0. Raising out_ready allows a new accept on the same edge.
- Reset mid-multiply: assert reset at MUL cycle 3. Next cycle out_valid=0, ALU_out=0, flags=0. No stray result appears afterward, and in_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with eight operations
// (add, sub, and, or, xor, shl, sar, multi-cycle unsigned mul) and
// four status flags, holding one operation in flight at a time.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake for src_a, src_b, ALU_Control
//   src_a, src_b        operands; low $clog2(WIDTH) bits of src_b = shift amount
//   ALU_Control         000 add, 001 sub, 010 and, 011 or, 100 xor,
//                       101 shl, 110 sar, 111 mul
//   out_valid/out_ready result handshake
//   ALU_out             registered result
//   zero/carry/sign/overflow_flag  registered flags, loaded with ALU_out
//
// State table:
//   IDLE | accepting ops; non-mul results are registered at the accept edge
//   MUL  | iterating shift-add multiply, one step per cycle

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       ALU_Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SAR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t               state_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     alu_out_q;
    logic                 zero_q;
    logic                 carry_q;
    logic                 sign_q;
    logic                 ovf_q;

    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;

    logic                 accept;
    logic [SW-1:0]        shamt;
    logic [WIDTH:0]       add_ext;
    logic [WIDTH:0]       sub_ext;
    logic [WIDTH:0]       shl_ext;
    logic [WIDTH:0]       sar_ext;
    logic [WIDTH-1:0]     res_d;
    logic                 carry_d;
    logic                 ovf_d;
    logic [2*WIDTH-1:0]   acc_d;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !reset;
    assign accept   = in_valid && in_ready;

    assign out_valid     = out_valid_q;
    assign ALU_out       = alu_out_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign sign_flag     = sign_q;
    assign overflow_flag = ovf_q;

    assign shamt = src_b[SW-1:0];

    // Shifts carry one extra bit: for shl the bit above the MSB, for sar the
    // bit below the LSB. That extra bit is the last bit shifted out, and is
    // naturally 0 when the shift amount is 0.
    always_comb begin
        add_ext = {1'b0, src_a} + {1'b0, src_b};
        sub_ext = {1'b0, src_a} - {1'b0, src_b};
        shl_ext = {1'b0, src_a} << shamt;
        sar_ext = $signed({src_a, 1'b0}) >>> shamt;
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (ALU_Control)
            OP_ADD: begin
                res_d   = add_ext[WIDTH-1:0];
                carry_d = add_ext[WIDTH];
                ovf_d   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = sub_ext[WIDTH-1:0];
                carry_d = sub_ext[WIDTH];
                ovf_d   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: res_d = src_a & src_b;
            OP_OR:  res_d = src_a | src_b;
            OP_XOR: res_d = src_a ^ src_b;
            OP_SHL: begin
                res_d   = shl_ext[WIDTH-1:0];
                carry_d = shl_ext[WIDTH];
            end
            OP_SAR: begin
                res_d   = sar_ext[WIDTH:1];
                carry_d = sar_ext[0];
            end
            OP_MUL: res_d = '0;
            default: res_d = '0;
        endcase
    end

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            // Consume first; a load later in this block overrides it.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (ALU_Control == OP_MUL) begin
                            state_q  <= MUL;
                            mcand_q  <= {{WIDTH{1'b0}}, src_a};
                            mplier_q <= src_b;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                        end else begin
                            out_valid_q <= 1'b1;
                            alu_out_q   <= res_d;
                            zero_q      <= (res_d == '0);
                            carry_q     <= carry_d;
                            sign_q      <= res_d[WIDTH-1];
                            ovf_q       <= ovf_d;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= acc_d[WIDTH-1:0];
                        zero_q      <= (acc_d[WIDTH-1:0] == '0);
                        carry_q     <= |acc_d[2*WIDTH-1:WIDTH];
                        sign_q      <= acc_d[WIDTH-1];
                        ovf_q       <= |acc_d[2*WIDTH-1:WIDTH];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized traffic for alu_seq,
// compared each cycle against a transaction-level reference model.

module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [2:0]   ALU_Control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_out;
    logic         zero_flag;
    logic         carry_flag;
    logic         sign_flag;
    logic         overflow_flag;

    alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src_a         (src_a),
        .src_b         (src_b),
        .ALU_Control   (ALU_Control),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_out       (ALU_out),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .sign_flag     (sign_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_valid = 0;
    int m_out   = 0;
    int m_c     = 0;
    int m_v     = 0;
    int m_z     = 0;
    int m_s     = 0;
    int m_busy  = 0;
    int p_out   = 0;
    int p_c     = 0;
    int p_v     = 0;
    int last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_op(input int op, input int a, input int b,
                                   output int r, output int c, output int v);
        int sa, sb, s, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        s  = b % W;
        r = 0; c = 0; v = 0;
        case (op)
            0: begin
                t = a + b; r = t % 256; c = (t > 255) ? 1 : 0;
                v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            1: begin
                r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
                v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = (a << s) % 256;
                c = (s == 0) ? 0 : ((a >> (W - s)) & 1);
            end
            6: begin
                r = (sa >>> s) & 255;
                c = (s == 0) ? 0 : ((a >> (s - 1)) & 1);
            end
            default: begin
                t = a * b; r = t % 256; c = (t > 255) ? 1 : 0; v = c;
            end
        endcase
    endfunction

    function automatic int m_rdy();
        return (m_busy == 0 && (m_valid == 0 || out_ready) && !reset) ? 1 : 0;
    endfunction

    task automatic m_load(input int r, input int c, input int v);
        m_out = r; m_c = c; m_v = v;
        m_z = (r == 0) ? 1 : 0;
        m_s = (r >= 128) ? 1 : 0;
        m_valid = 1;
    endtask

    task automatic check_outputs();
        chk("in_ready",  32'(in_ready),      m_rdy());
        chk("out_valid", 32'(out_valid),     m_valid);
        chk("ALU_out",   32'(ALU_out),       m_out);
        chk("zero",      32'(zero_flag),     m_z);
        chk("carry",     32'(carry_flag),    m_c);
        chk("sign",      32'(sign_flag),     m_s);
        chk("overflow",  32'(overflow_flag), m_v);
    endtask

    // One clock: capture the pre-edge view, advance the model across the
    // edge, then compare on the falling edge.
    task automatic cycle();
        int acc, cons, rst, op, a, b, r, c, v;
        rst  = reset ? 1 : 0;
        acc  = (m_rdy() != 0 && in_valid) ? 1 : 0;
        cons = (m_valid != 0 && out_ready) ? 1 : 0;
        op = int'(ALU_Control); a = int'(src_a); b = int'(src_b);
        @(posedge clk);
        if (rst != 0) begin
            m_valid = 0; m_out = 0; m_c = 0; m_v = 0; m_z = 0; m_s = 0; m_busy = 0;
        end else begin
            if (cons != 0) m_valid = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_load(p_out, p_c, p_v);
            end else if (acc != 0) begin
                ref_op(op, a, b, r, c, v);
                if (op == 7) begin
                    m_busy = W; p_out = r; p_c = c; p_v = v;
                end else begin
                    m_load(r, c, v);
                end
            end
        end
        last_acc = acc;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int done;
        in_valid = 1'b1; ALU_Control = op; src_a = a; src_b = b;
        done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            cycle();
            done = last_acc;
        end
        if (done == 0) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    logic [W-1:0] corner [5];

    initial begin
        corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80;
        corner[3] = 8'hFF; corner[4] = 8'h01;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; ALU_Control = 3'b000;
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_in_ready", 32'(in_ready), 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Signed-overflow add
        issue(3'b000, 8'h7F, 8'h01);
        chk("add_ovf_out",  32'(ALU_out), 'h80);
        chk("add_ovf_v",    32'(overflow_flag), 1);
        chk("add_ovf_c",    32'(carry_flag), 0);
        chk("add_ovf_vld",  32'(out_valid), 1);

        // Borrow and signed overflow on sub
        issue(3'b001, 8'h00, 8'h01);
        chk("sub_borrow_out", 32'(ALU_out), 'hFF);
        chk("sub_borrow_c",   32'(carry_flag), 1);
        issue(3'b001, 8'h80, 8'h01);
        chk("sub_ovf_out", 32'(ALU_out), 'h7F);
        chk("sub_ovf_v",   32'(overflow_flag), 1);

        // Multiply with high half non-zero, then exactly 0xFF
        issue(3'b111, 8'h10, 8'h10);
        for (int i = 1; i < W; i++) begin
            cycle();
            chk("mul_busy_rdy", 32'(in_ready), 0);
        end
        chk("mul_not_yet", 32'(out_valid), 0);
        cycle();
        chk("mul_vld",  32'(out_valid), 1);
        chk("mul_out",  32'(ALU_out), 'h00);
        chk("mul_zero", 32'(zero_flag), 1);
        chk("mul_c",    32'(carry_flag), 1);
        issue(3'b111, 8'h0F, 8'h11);
        // Operands changed mid-flight must not matter
        src_a = 8'h55; src_b = 8'hAA; ALU_Control = 3'b000;
        repeat (W) cycle();
        chk("mul2_out", 32'(ALU_out), 'hFF);
        chk("mul2_c",   32'(carry_flag), 0);

        // Back-to-back shifts and xor
        in_valid = 1'b1;
        ALU_Control = 3'b110; src_a = 8'h81; src_b = 8'h01;
        cycle();
        chk("sar_out", 32'(ALU_out), 'hC0);
        chk("sar_c",   32'(carry_flag), 1);
        ALU_Control = 3'b101; src_a = 8'h81; src_b = 8'h01;
        cycle();
        chk("shl_out", 32'(ALU_out), 'h02);
        chk("shl_c",   32'(carry_flag), 1);
        ALU_Control = 3'b100; src_a = 8'hAA; src_b = 8'hAA;
        cycle();
        chk("xor_out",  32'(ALU_out), 'h00);
        chk("xor_zero", 32'(zero_flag), 1);
        in_valid = 1'b0;
        cycle();

        // Backpressure
        issue(3'b000, 8'h12, 8'h34);
        out_ready = 1'b0;
        in_valid = 1'b1; ALU_Control = 3'b000; src_a = 8'h01; src_b = 8'h01;
        repeat (5) begin
            cycle();
            chk("bp_hold_out", 32'(ALU_out), 'h46);
            chk("bp_rdy",      32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 1);
        cycle();
        chk("bp_new_out", 32'(ALU_out), 'h02);
        in_valid = 1'b0;
        cycle();

        // Reset during multiply
        issue(3'b111, 8'h33, 8'h44);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mul_vld", 32'(out_valid), 0);
        chk("rst_mul_out", 32'(ALU_out), 0);
        reset = 1'b0;
        #1;
        chk("rst_mul_rdy", 32'(in_ready), 1);
        repeat (12) cycle();

        // Randomized traffic with backpressure
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc != 0) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                ALU_Control = 3'($urandom_range(0, 7));
                src_a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
                src_b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
